// File: rtl/index_write_scheduler.sv
// Single write port arbiter for the monitor_index frame memory: round-robin between the
// text renderer and trajectory plotter, plus a full-frame clear engine.
module index_write_scheduler #(
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned ADDR_W      = 19,
    parameter logic [2:0]  BG_INDEX    = 3'd0
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              clear_start,
    input  logic              txt_valid,
    input  logic [ADDR_W-1:0] txt_addr,
    input  logic [2:0]        txt_data,
    output logic              txt_ready,
    input  logic              trj_valid,
    input  logic [ADDR_W-1:0] trj_addr,
    input  logic [2:0]        trj_data,
    output logic              trj_ready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [2:0]        mem_wdata,
    output logic              mem_wenable,
    output logic              busy,
    output logic              clear_done,
    output logic              oob_drop
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_WORDS - 32'd1);
    // One extra bit so FRAME_WORDS itself is representable for the range test.
    localparam logic [ADDR_W:0]   FRAME_LIMIT = (ADDR_W + 1)'(FRAME_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_trj_q, last_trj_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [2:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              oob_q, oob_d;

    logic              grant_txt_s;
    logic              grant_trj_s;
    logic              txt_in_range_s;
    logic              trj_in_range_s;

    // Grant selection: round-robin on ties, blocked while clearing or on a clear request.
    always_comb begin
        grant_txt_s = 1'b0;
        grant_trj_s = 1'b0;
        if ((state_q == ST_ARB) && !clear_start) begin
            grant_txt_s = txt_valid && (!trj_valid || last_trj_q);
            grant_trj_s = trj_valid && (!txt_valid || !last_trj_q);
        end else begin
            grant_txt_s = 1'b0;
            grant_trj_s = 1'b0;
        end
    end

    assign txt_ready      = grant_txt_s;
    assign trj_ready      = grant_trj_s;
    assign txt_in_range_s = ({1'b0, txt_addr} < FRAME_LIMIT);
    assign trj_in_range_s = ({1'b0, trj_addr} < FRAME_LIMIT);

    // Next-state and next-output computation for the arbiter and the clear engine.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_trj_d = last_trj_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        oob_d      = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (grant_txt_s) begin
                    last_trj_d = 1'b0;
                    waddr_d    = txt_addr;
                    wdata_d    = txt_data;
                    we_d       = txt_in_range_s;
                    oob_d      = !txt_in_range_s;
                end else if (grant_trj_s) begin
                    last_trj_d = 1'b1;
                    waddr_d    = trj_addr;
                    wdata_d    = trj_data;
                    we_d       = trj_in_range_s;
                    oob_d      = !trj_in_range_s;
                end else begin
                    we_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = BG_INDEX;
                // The final clear write leaves CLEAR so grants resume as it reaches memory.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_ARB;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + ADDR_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_ARB;
            cnt_q      <= '0;
            last_trj_q <= 1'b1;
            waddr_q    <= '0;
            wdata_q    <= 3'd0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_trj_q <= last_trj_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            oob_q      <= oob_d;
        end
    end

    assign mem_waddr   = waddr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wenable = we_q;
    assign busy        = busy_q;
    assign clear_done  = done_q;
    assign oob_drop    = oob_q;

endmodule
